// File: rtl/maxpool_pkg.sv
// ---------------------------------------------------------------------------
// maxpool_pkg
// Shared definitions for the 2x2 / stride-2 pooling and unpooling blocks.
//   DATA_W     : default width of a pixel / pooled value
//   win_idx_t  : argmax position inside a 2x2 window, encoded as 2*i + j
//                (bit1 = row offset i, bit0 = column offset j)
//   pool_state_e : frame-level state machine shared by the streaming blocks
// ---------------------------------------------------------------------------
package maxpool_pkg;

  localparam int DATA_W = 16;

  typedef logic [1:0] win_idx_t;

  localparam win_idx_t IDX_TOP_LEFT  = 2'b00;
  localparam win_idx_t IDX_TOP_RIGHT = 2'b01;
  localparam win_idx_t IDX_BOT_LEFT  = 2'b10;
  localparam win_idx_t IDX_BOT_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    REPLAY = 2'd2,
    DONE   = 2'd3
  } pool_state_e;

  // Builds the window index for row offset i and column offset j.
  function automatic win_idx_t make_win_idx(input logic i, input logic j);
    return {i, j};
  endfunction

endpackage

// File: rtl/unpool_row_buf.sv
// ---------------------------------------------------------------------------
// unpool_row_buf
// Holds one pooled row of {value, window index} entries so the odd output
// row can be regenerated after the even row has been streamed out.
//   clk      : clock
//   wr_en    : write strobe, wr_addr / wr_data select entry and contents
//   rd_en    : read strobe, rd_addr selects entry
//   rd_data  : registered read data, valid the cycle after rd_en
// Contents are not reset; every entry is written before it is read.
// ---------------------------------------------------------------------------
module unpool_row_buf
  import maxpool_pkg::*;
#(
  parameter int DEPTH  = 31,
  parameter int WIDTH  = DATA_W + $bits(win_idx_t),
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Simple dual-port storage: one write and one registered read per cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/max_unpool_stream.sv
// ---------------------------------------------------------------------------
// max_unpool_stream
// Streaming 2x2 max-unpooling. Each pooled element {value, argmax index}
// expands into a 2x2 block of output pixels holding the value at the argmax
// position and zero elsewhere. Even output rows are produced while the
// pooled row streams in; the pooled row is kept in a row buffer and replayed
// to produce the following odd output row.
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin one frame (accepted in IDLE or DONE)
//   in_valid/in_ready   : pooled element handshake, in_data / in_idx payload
//   out_valid/out_ready : output pixel handshake, out_data payload
//   out_eol, out_last   : last pixel of a row / of the frame
//   busy, done          : frame in progress / frame complete
// ---------------------------------------------------------------------------
module max_unpool_stream #(
  parameter int FM_height = 62,
  parameter int FM_width  = 62,
  parameter int DATA_W    = maxpool_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  maxpool_pkg::win_idx_t in_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_eol,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  import maxpool_pkg::*;

  localparam int HALF_W  = FM_width / 2;
  localparam int HALF_H  = FM_height / 2;
  localparam int ADDR_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int PR_W    = (HALF_H > 1) ? $clog2(HALF_H) : 1;
  localparam int FC_W    = $clog2(HALF_W + 1);
  localparam int ENTRY_W = DATA_W + $bits(win_idx_t);

  localparam logic [ADDR_W-1:0] PC_LAST  = ADDR_W'(HALF_W - 1);
  localparam logic [PR_W-1:0]   PR_LAST  = PR_W'(HALF_H - 1);
  localparam logic [FC_W-1:0]   FC_COUNT = FC_W'(HALF_W);

  // Value of one output beat: the pooled value if this beat sits at the argmax.
  function automatic logic [DATA_W-1:0] beat_value(input logic [DATA_W-1:0] value,
                                                   input win_idx_t idx,
                                                   input logic i, input logic j);
    return (idx == make_win_idx(i, j)) ? value : '0;
  endfunction

  pool_state_e          state_q, state_d;
  logic [PR_W-1:0]      pr_q, pr_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [FC_W-1:0]      fc_q, fc_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 hold_valid_q, hold_valid_d;
  logic                 beat_q, beat_d;
  logic [DATA_W-1:0]    hold_data_q, hold_data_d;
  win_idx_t             hold_idx_q, hold_idx_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic                 out_eol_q, out_eol_d;
  logic                 out_last_q, out_last_d;

  logic                 in_frame, row_odd, out_hs, pair_done;
  logic                 pc_at_end, pr_at_end, accept_ok, src_valid, take;
  logic [DATA_W-1:0]    src_data;
  win_idx_t             src_idx;
  logic                 wr_en, rd_en;
  logic [ADDR_W-1:0]    wr_addr, rd_addr;
  logic [ENTRY_W-1:0]   rb_rd_data;

  // Handshake and source selection. The holding register frees up in the
  // same cycle its second beat is accepted, so a new element can be taken
  // back-to-back and the output runs at one beat per cycle. The element that
  // closes a pooled row is never followed by a bypass take, because the next
  // element belongs to a different phase.
  always_comb begin
    in_frame  = (state_q == LOAD) || (state_q == REPLAY);
    row_odd   = (state_q == REPLAY);
    out_hs    = out_valid_q && out_ready;
    pair_done = out_hs && beat_q;
    pc_at_end = (pc_q == PC_LAST);
    pr_at_end = (pr_q == PR_LAST);
    accept_ok = in_frame && (!hold_valid_q || (pair_done && !pc_at_end));

    src_valid = 1'b0;
    src_data  = in_data;
    src_idx   = in_idx;
    if (state_q == LOAD) begin
      src_valid = in_valid;
    end else if (state_q == REPLAY) begin
      src_valid = rd_pend_q;
      src_data  = rb_rd_data[ENTRY_W-1 -: DATA_W];
      src_idx   = rb_rd_data[$bits(win_idx_t)-1:0];
    end
    take = accept_ok && src_valid;

    in_ready = (state_q == LOAD) && accept_ok;
    wr_en    = (state_q == LOAD) && take;
    wr_addr  = hold_valid_q ? (pc_q + 1'b1) : pc_q;
    rd_en    = (state_q == REPLAY) && (fc_q != FC_COUNT) && (!rd_pend_q || take);
    rd_addr  = fc_q[ADDR_W-1:0];
  end

  // Next-state logic for the frame FSM, counters, holding register and the
  // registered output stage. Replay reads are prefetched one entry ahead so
  // the row buffer's read latency is hidden behind the current pair of beats.
  always_comb begin
    state_d      = state_q;
    pr_d         = pr_q;
    pc_d         = pc_q;
    fc_d         = fc_q;
    rd_pend_d    = rd_pend_q;
    hold_valid_d = hold_valid_q;
    beat_d       = beat_q;
    hold_data_d  = hold_data_q;
    hold_idx_d   = hold_idx_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_eol_d    = out_eol_q;
    out_last_d   = out_last_q;

    if (rd_en) begin
      rd_pend_d = 1'b1;
      fc_d      = fc_q + 1'b1;
    end else if (take) begin
      rd_pend_d = 1'b0;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = LOAD;
          pr_d         = '0;
          pc_d         = '0;
          fc_d         = '0;
          rd_pend_d    = 1'b0;
          hold_valid_d = 1'b0;
        end
      end

      LOAD, REPLAY: begin
        if (out_hs && !beat_q) begin
          beat_d     = 1'b1;
          out_data_d = beat_value(hold_data_q, hold_idx_q, row_odd, 1'b1);
          out_eol_d  = pc_at_end;
          out_last_d = pc_at_end && row_odd && pr_at_end;
        end

        if (pair_done) begin
          hold_valid_d = 1'b0;
          out_valid_d  = 1'b0;
          out_data_d   = '0;
          out_eol_d    = 1'b0;
          out_last_d   = 1'b0;
          if (pc_at_end) begin
            pc_d = '0;
            if (state_q == LOAD) begin
              state_d   = REPLAY;
              fc_d      = '0;
              rd_pend_d = 1'b0;
            end else if (pr_at_end) begin
              state_d = DONE;
            end else begin
              pr_d    = pr_q + 1'b1;
              state_d = LOAD;
            end
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end

        if (take) begin
          hold_valid_d = 1'b1;
          hold_data_d  = src_data;
          hold_idx_d   = src_idx;
          beat_d       = 1'b0;
          out_valid_d  = 1'b1;
          out_data_d   = beat_value(src_data, src_idx, row_odd, 1'b0);
          out_eol_d    = 1'b0;
          out_last_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State register; reset returns the block to an empty, idle frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pr_q         <= '0;
      pc_q         <= '0;
      fc_q         <= '0;
      rd_pend_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      beat_q       <= 1'b0;
      hold_data_q  <= '0;
      hold_idx_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_eol_q    <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pr_q         <= pr_d;
      pc_q         <= pc_d;
      fc_q         <= fc_d;
      rd_pend_q    <= rd_pend_d;
      hold_valid_q <= hold_valid_d;
      beat_q       <= beat_d;
      hold_data_q  <= hold_data_d;
      hold_idx_q   <= hold_idx_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_eol_q    <= out_eol_d;
      out_last_q   <= out_last_d;
    end
  end

  unpool_row_buf #(
    .DEPTH  (HALF_W),
    .WIDTH  (ENTRY_W),
    .ADDR_W (ADDR_W)
  ) u_row_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({in_data, in_idx}),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rb_rd_data)
  );

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_eol   = out_eol_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == LOAD) || (state_q == REPLAY);
  assign done      = (state_q == DONE);

endmodule

// File: doc/max_unpool_stream.md
MAX_UNPOOL_STREAM -- requirements
Module: max_unpool_stream

Interface
REQ-001 Parameter FM_height, default 62, full-resolution output height in rows; SHALL be even.
REQ-002 Parameter FM_width, default 62, full-resolution output width in columns; SHALL be even.
REQ-003 Parameter DATA_W, default 16, value width in bits; window fixed KERNEL=STRIDE=2.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  begin one frame; sampled only in IDLE or DONE.
REQ-007 in_valid  in  1  pooled element present.
REQ-008 in_ready  out  1  block accepts the pooled element this cycle.
REQ-009 in_data  in  DATA_W  pooled max value, raster order (row-major, FM_width/2 per row).
REQ-010 in_idx  in  2  argmax position in the 2x2 window: bit1 = row offset i, bit0 = col offset j (idx = 2i+j).
REQ-011 out_valid  out  1  full-resolution pixel present.
REQ-012 out_ready  in  1  downstream accepts the pixel.
REQ-013 out_data  out  DATA_W  pixel value: pooled value at the argmax position, 0 elsewhere.
REQ-014 out_eol  out  1  high with the last pixel of each output row.
REQ-015 out_last  out  1  high with the final pixel of the frame.
REQ-016 busy  out  1  frame in progress; done  out  1  frame complete, held until start or rst.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, REPLAY and DONE.
REQ-018 In IDLE or DONE, start=1 SHALL move to LOAD, clear done and zero the pooled-row counter pr and the pooled-column counter pc on the next edge.
REQ-019 In LOAD, in_ready SHALL be 1 only while the holding register is empty; a handshake (in_valid & in_ready) SHALL write {in_data,in_idx} into the holding register and into row-buffer entry pc.
REQ-020 Each held element SHALL produce two output beats, output row 2*pr, columns 2*pc and 2*pc+1; a beat carries the value iff idx=={0,0} or idx=={0,1} respectively, else 0.
REQ-021 The holding register SHALL empty on the handshake of its second beat; pc then increments, and at pc==FM_width/2-1 the FSM SHALL enter REPLAY with pc=0.
REQ-022 In REPLAY, the block SHALL emit output row 2*pr+1 from the row buffer, two beats per entry, with the value at idx=={1,0} or idx=={1,1}, else 0; in_ready SHALL be 0.
REQ-023 At the end of REPLAY, if pr==FM_height/2-1 the FSM SHALL enter DONE (done=1, busy=0), else it SHALL increment pr and return to LOAD.
REQ-024 out_data, out_eol and out_last SHALL be held stable while out_valid=1 and out_ready=0; out_valid SHALL not drop before the handshake.
REQ-025 out_eol SHALL be 1 on the beat at output column FM_width-1; out_last SHALL be 1 on that beat only in output row FM_height-1.
REQ-026 Throughput SHALL be one output beat per cycle when out_ready=1 (one input accepted per two LOAD cycles); latency from input handshake to its first output beat SHALL be 1 cycle.
REQ-027 in_valid with in_ready=0, in IDLE, DONE or REPLAY, SHALL be ignored (no state change).
REQ-028 start while busy SHALL be ignored.
REQ-029 out_valid SHALL be 0 in IDLE and DONE.

Reset
REQ-030 rst=1 SHALL, on the next edge and from any state including mid-frame, force IDLE, pr=pc=0, an empty holding register, in_ready=0, out_valid=0, out_data=0, out_eol=0, out_last=0, busy=0 and done=0.
REQ-031 Row-buffer contents need not be reset; they SHALL be overwritten before they are read.

Structure
REQ-032 The shared package maxpool_pkg SHALL hold DATA_W, the 2-bit window-index type with its encoding (2i+j) and the FSM state enumeration, shared with the pooling blocks.
REQ-033 The row buffer SHALL be a sub-module unpool_row_buf: FM_width/2 entries of DATA_W+2 bits, one write port, one read port, 1-cycle read.

Verification
REQ-034 FM 4x4, out_ready=1, inputs (5,0),(7,3),(9,1),(2,2) -> rows: 5 0 0 0 / 0 0 0 7 / 0 9 0 0 / 0 0 2 0; eol on cols 3; last on final beat; done=1.
REQ-035 Same stimulus, out_ready toggling 1-0 -> identical pixel sequence; out_data is stable during stalls.
REQ-036 in_valid asserted during REPLAY -> in_ready=0 and the element is accepted only in the next LOAD.
REQ-037 rst mid-frame after 3 pixels -> next edge IDLE with all outputs 0; new start then yields a correct full frame.
REQ-038 start pulsed while busy -> no effect; after DONE, start -> done clears and a second 4x4 frame completes correctly.
REQ-039 FM 62x62 random values and indices -> 3844 beats, exactly 961 nonzero at argmax positions, matching a reference model.
